mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the memory controller's single shared read/write data port among three requesters:
- the CPU memory stage (read/write),
- the image processor result path (write-only),
- the SPART read path (read-only).

Each requester holds a request until it receives a one-cycle valid pulse. Every requester sees the same registered, one-transaction-at-a-time protocol. The block sits between those requesters and the memory controller's CPU/data-port inputs. It gives the CPU priority while guaranteeing the other two bounded service.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CPU_BURST_MAX, 4, max consecutive CPU grants while another requester waits (1..15)
- TIMEOUT, 255, max cycles waiting for mem_vld before abort (1..255)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- cpu_req  in  1  CPU request, held until cpu_vld
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_vld
- cpu_vld  out  1  one-cycle completion pulse
- img_req  in  1  image-processor write request
- img_addr  in  ADDR_W  write address
- img_wdata  in  DATA_W  write data
- img_vld  out  1  one-cycle completion pulse
- spart_req  in  1  SPART read request
- spart_addr  in  ADDR_W  read address
- spart_rdata  out  DATA_W  read data, valid with spart_vld
- spart_vld  out  1  one-cycle completion pulse
- mem_req  out  1  request to memory controller, held until mem_vld
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  read data, valid with mem_vld
- mem_vld  in  1  memory controller completion
- grant  out  2  current owner: 0 none, 1 CPU, 2 IMG, 3 SPART
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst

## Operation
States:
- IDLE
  - If any request is high, select the winner. Latch its addr, wdata and wr (IMG forces wr = 1, SPART forces wr = 0). Set grant and go to BUSY.
  - If no request is high, stay in IDLE.
- BUSY
  - mem_req = 1 and the latched fields drive mem_* for the whole state.
  - On mem_vld: capture mem_rdata and go to RESP.
  - If the wait counter reaches TIMEOUT first: set timeout_err, load read data 32'hDEAD_BEEF, and go to RESP.
- RESP
  - Pulse the winner's *_vld for exactly one cycle; its *_rdata holds the captured word.
  - Go to IDLE; grant returns to 0.

Arbitration, evaluated only in IDLE:
- CPU wins if cpu_req = 1, unless cpu_streak == CPU_BURST_MAX and img_req or spart_req is high.
- Otherwise IMG and SPART share a round-robin pointer rr_ptr; rr_ptr toggles to the other requester after each IMG or SPART grant. If only one of them is requesting, it wins regardless of rr_ptr.
- cpu_streak:
  - increments (saturating at CPU_BURST_MAX) on a CPU grant while another requester is pending;
  - clears on a CPU grant with no other requester pending;
  - clears on any IMG or SPART grant.

Requester contract:
- Hold req and its address/data stable until *_vld.
- Deassert req the cycle after *_vld, or keep it high to start a new transaction; the earliest re-arbitration is in the IDLE cycle after RESP.
- The arbiter ignores request changes while in BUSY or RESP.

Reset:
- rst in any state returns to IDLE next edge and discards any in-flight transaction; no vld pulse is produced.
- Reset values: mem_req 0, mem_wr 0, mem_addr 0, mem_wdata 0, all *_vld 0, all *_rdata 0, grant 0, timeout_err 0, cpu_streak 0, rr_ptr = IMG, wait counter 0.

## Timing
- Request sampled in IDLE at cycle T: mem_req and mem_* are high/valid from T+1.
- mem_vld at cycle T+k (k ≥ 1, may equal T+1): requester *_vld at T+k+1; IDLE at T+k+2.
- Minimum transaction is 3 cycles (IDLE, BUSY, RESP); back-to-back grants occur every 3 cycles at minimum.
- Wait counter: 8 bits, clears on BUSY entry, increments each BUSY cycle without mem_vld.
  - Abort when count == TIMEOUT, i.e. after TIMEOUT+1 BUSY cycles.
  - mem_vld in the same cycle as the timeout wins: normal completion, no error.
- *_rdata hold their value until the next completion for that requester.
- For write transactions, *_rdata is updated with mem_rdata as captured (don't-care).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- CPU read alone:
  - stimulus: cpu_req = 1, cpu_wr = 0, addr 0x10; memory returns 0x1234_5678 with mem_vld one cycle after mem_req;
  - required: mem_req from T+1 with mem_addr 0x10; cpu_vld for one cycle with cpu_rdata 0x1234_5678; grant sequence 1 then 0.
- Starvation bound:
  - stimulus: cpu_req and img_req both held high continuously, CPU_BURST_MAX = 4;
  - required: grant sequence CPU, CPU, CPU, CPU, IMG, CPU, …; img_vld is seen within 5 transactions.
- Round-robin:
  - stimulus: img_req and spart_req high, cpu_req low;
  - required: grants alternate IMG, SPART, IMG; mem_wr is 1 for IMG grants and 0 for SPART grants.
- Timeout:
  - stimulus: SPART read, mem_vld never asserted, TIMEOUT = 8;
  - required: mem_req drops after 9 BUSY cycles; spart_vld pulses with 0xDEAD_BEEF; timeout_err stays 1 until rst.
- Reset mid-transaction:
  - stimulus: rst asserted during BUSY;
  - required: next cycle all outputs are at reset values, no vld pulse, and a subsequent request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the memory controller's single data port among the CPU, image-processor
// and SPART requesters: CPU priority with a burst cap, round-robin between the others.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int CPU_BURST_MAX = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_vld,
    input  logic              img_req,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_wdata,
    output logic              img_vld,
    input  logic              spart_req,
    input  logic [ADDR_W-1:0] spart_addr,
    output logic [DATA_W-1:0] spart_rdata,
    output logic              spart_vld,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_vld,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_CPU   = 2'd1;
    localparam logic [1:0] GNT_IMG   = 2'd2;
    localparam logic [1:0] GNT_SPART = 2'd3;

    localparam logic [3:0] BURST_MAX = 4'(CPU_BURST_MAX);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        win_s;
    logic              done_s;
    logic              abort_s;
    logic              other_s;
    logic [DATA_W-1:0] cap_data_s;
    logic [3:0]        cpu_streak_r;
    logic              rr_ptr_r;      // 0 = IMG next, 1 = SPART next
    logic [7:0]        wait_cnt_r;

    // Next-state, arbitration winner and completion/abort decode
    always_comb begin
        state_next_s = state_r;
        win_s        = GNT_NONE;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        other_s      = img_req | spart_req;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req && !((cpu_streak_r == BURST_MAX) && other_s)) begin
                    win_s = GNT_CPU;
                end else if (img_req && spart_req) begin
                    win_s = rr_ptr_r ? GNT_SPART : GNT_IMG;
                end else if (img_req) begin
                    win_s = GNT_IMG;
                end else if (spart_req) begin
                    win_s = GNT_SPART;
                end else begin
                    win_s = GNT_NONE;
                end
                if (win_s != GNT_NONE) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A completion in the timeout cycle still counts as a normal completion
                if (mem_vld) begin
                    done_s       = 1'b1;
                    state_next_s = ST_RESP;
                end else if (wait_cnt_r == TMO_LIMIT) begin
                    abort_s      = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (done_s) begin
            cap_data_s = mem_rdata;
        end else begin
            cap_data_s = DATA_W'(32'hDEAD_BEEF);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Port latching, response pulses, streak/round-robin bookkeeping and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= {DATA_W{1'b0}};
            cpu_vld      <= 1'b0;
            img_vld      <= 1'b0;
            spart_vld    <= 1'b0;
            cpu_rdata    <= {DATA_W{1'b0}};
            spart_rdata  <= {DATA_W{1'b0}};
            grant        <= GNT_NONE;
            timeout_err  <= 1'b0;
            cpu_streak_r <= 4'd0;
            rr_ptr_r     <= 1'b0;
            wait_cnt_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (win_s != GNT_NONE) begin
                        mem_req    <= 1'b1;
                        grant      <= win_s;
                        wait_cnt_r <= 8'd0;
                    end
                    case (win_s)
                        GNT_CPU: begin
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                            mem_wr    <= cpu_wr;
                            if (!other_s) begin
                                cpu_streak_r <= 4'd0;
                            end else if (cpu_streak_r < BURST_MAX) begin
                                cpu_streak_r <= cpu_streak_r + 4'd1;
                            end
                        end
                        GNT_IMG: begin
                            mem_addr     <= img_addr;
                            mem_wdata    <= img_wdata;
                            mem_wr       <= 1'b1;
                            rr_ptr_r     <= 1'b1;
                            cpu_streak_r <= 4'd0;
                        end
                        GNT_SPART: begin
                            mem_addr     <= spart_addr;
                            mem_wdata    <= {DATA_W{1'b0}};
                            mem_wr       <= 1'b0;
                            rr_ptr_r     <= 1'b0;
                            cpu_streak_r <= 4'd0;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_BUSY: begin
                    if (done_s || abort_s) begin
                        mem_req <= 1'b0;
                        case (grant)
                            GNT_CPU: begin
                                cpu_vld   <= 1'b1;
                                cpu_rdata <= cap_data_s;
                            end
                            GNT_IMG: begin
                                img_vld <= 1'b1;
                            end
                            GNT_SPART: begin
                                spart_vld   <= 1'b1;
                                spart_rdata <= cap_data_s;
                            end
                            default: begin
                            end
                        endcase
                        if (abort_s) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    cpu_vld   <= 1'b0;
                    img_vld   <= 1'b0;
                    spart_vld <= 1'b0;
                    grant     <= GNT_NONE;
                end
                default: begin
                    mem_req <= 1'b0;
                    grant   <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a latency-programmable
// memory responder; CPU_BURST_MAX = 4, TIMEOUT = 8.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_vld;
    logic        img_req;
    logic [31:0] img_addr, img_wdata;
    logic        img_vld;
    logic        spart_req;
    logic [31:0] spart_addr, spart_rdata;
    logic        spart_vld;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_vld;
    logic [1:0]  grant;
    logic        timeout_err;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat;
    int          busy_seen;
    logic [31:0] resp_data;
    logic [31:0] rd;
    logic [1:0]  starve_grant [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .CPU_BURST_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_vld(cpu_vld),
        .img_req(img_req), .img_addr(img_addr), .img_wdata(img_wdata), .img_vld(img_vld),
        .spart_req(spart_req), .spart_addr(spart_addr), .spart_rdata(spart_rdata),
        .spart_vld(spart_vld),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_vld(mem_vld),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory responder: raises mem_vld for one cycle in the mem_lat-th cycle of mem_req
    initial begin
        mem_vld   = 1'b0;
        mem_rdata = 32'd0;
        busy_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_vld) begin
                mem_vld   = 1'b0;
                busy_seen = 0;
            end else if (!mem_req) begin
                busy_seen = 0;
            end else begin
                busy_seen++;
                if (mem_lat != 0 && busy_seen >= mem_lat) begin
                    mem_vld   = 1'b1;
                    mem_rdata = resp_data;
                end
            end
        end
    end

    // One transaction from an IDLE cycle: grant/port checks, then exactly one owner vld pulse
    task automatic run_txn(input logic [1:0] g, input logic wr, input logic [31:0] addr,
                           output logic [31:0] rdat);
        int n;
        int pulses;
        n = 0;
        while (grant == 2'd0 && n < 30) begin
            tick;
            n++;
        end
        check_eq("grant_latency", 64'(n), 64'd1);
        check_eq("grant", 64'(grant), 64'(g));
        check_eq("mem_req", 64'(mem_req), 64'd1);
        check_eq("mem_wr", 64'(mem_wr), 64'(wr));
        check_eq("mem_addr", 64'(mem_addr), 64'(addr));
        pulses = 0;
        rdat   = 32'd0;
        n      = 0;
        while (grant != 2'd0 && n < 40) begin
            tick;
            n++;
            case (g)
                2'd1: if (cpu_vld) begin pulses++; rdat = cpu_rdata; end
                2'd2: if (img_vld) begin pulses++; end
                2'd3: if (spart_vld) begin pulses++; rdat = spart_rdata; end
                default: begin end
            endcase
        end
        check_eq("vld_pulses", 64'(pulses), 64'd1);
    endtask

    initial begin
        int n;
        int busy;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        img_req = 1'b0; img_addr = 32'h0000_0200; img_wdata = 32'h1111_2222;
        spart_req = 1'b0; spart_addr = 32'h0000_0300;
        mem_lat = 1; resp_data = 32'd0;
        repeat (2) tick;
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_timeout_err", 64'(timeout_err), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        rst = 1'b0;
        tick;

        // CPU read alone
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0010;
        resp_data = 32'h1234_5678;
        run_txn(2'd1, 1'b0, 32'h0000_0010, rd);
        check_eq("cpu_read_data", 64'(rd), 64'h1234_5678);
        cpu_req = 1'b0;
        tick;
        check_eq("cpu_idle_grant", 64'(grant), 64'd0);
        check_eq("cpu_vld_single", 64'(cpu_vld), 64'd0);
        check_eq("cpu_rdata_hold", 64'(cpu_rdata), 64'h1234_5678);

        // Round-robin IMG / SPART
        img_req = 1'b1; spart_req = 1'b1;
        resp_data = 32'hA5A5_0001;
        run_txn(2'd2, 1'b1, 32'h0000_0200, rd);
        run_txn(2'd3, 1'b0, 32'h0000_0300, rd);
        check_eq("rr_spart_data", 64'(rd), 64'hA5A5_0001);
        run_txn(2'd2, 1'b1, 32'h0000_0200, rd);
        spart_req = 1'b0;

        // Starvation bound: CPU x4, IMG, CPU
        cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_txn(starve_grant[i], (starve_grant[i] == 2'd2) ? 1'b1 : 1'b0,
                    (starve_grant[i] == 2'd2) ? 32'h0000_0200 : 32'h0000_0010, rd);
        end
        cpu_req = 1'b0; img_req = 1'b0;
        tick;

        // Timeout: SPART read with no mem_vld
        mem_lat = 0;
        spart_req = 1'b1;
        tick;
        check_eq("tmo_grant", 64'(grant), 64'd3);
        busy = 1;
        n = 0;
        while (!spart_vld && n < 30) begin
            tick;
            n++;
            if (mem_req) busy++;
        end
        check_eq("tmo_busy_cycles", 64'(busy), 64'd9);
        check_eq("tmo_spart_vld", 64'(spart_vld), 64'd1);
        check_eq("tmo_spart_rdata", 64'(spart_rdata), 64'hDEAD_BEEF);
        check_eq("tmo_err_set", 64'(timeout_err), 64'd1);
        check_eq("tmo_mem_req_low", 64'(mem_req), 64'd0);
        spart_req = 1'b0;
        tick;
        check_eq("tmo_vld_single", 64'(spart_vld), 64'd0);
        check_eq("tmo_err_sticky", 64'(timeout_err), 64'd1);

        // Reset during BUSY
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h0000_0044; cpu_wdata = 32'h5555_AAAA;
        tick;
        check_eq("rb_grant", 64'(grant), 64'd1);
        check_eq("rb_mem_wr", 64'(mem_wr), 64'd1);
        check_eq("rb_mem_wdata", 64'(mem_wdata), 64'h5555_AAAA);
        tick;
        rst = 1'b1;
        tick;
        check_eq("rb_mem_req", 64'(mem_req), 64'd0);
        check_eq("rb_grant_clr", 64'(grant), 64'd0);
        check_eq("rb_cpu_vld", 64'(cpu_vld), 64'd0);
        check_eq("rb_timeout_err", 64'(timeout_err), 64'd0);
        check_eq("rb_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rb_spart_rdata", 64'(spart_rdata), 64'd0);
        rst = 1'b0;
        cpu_wr = 1'b0;
        mem_lat = 1;
        resp_data = 32'hCAFE_0002;
        run_txn(2'd1, 1'b0, 32'h0000_0044, rd);
        check_eq("rb_after_data", 64'(rd), 64'hCAFE_0002);
        cpu_req = 1'b0;

        // mem_vld in the timeout cycle completes normally
        mem_lat = 9;
        resp_data = 32'h0BAD_F00D;
        spart_req = 1'b1;
        run_txn(2'd3, 1'b0, 32'h0000_0300, rd);
        check_eq("edge_data", 64'(rd), 64'h0BAD_F00D);
        check_eq("edge_no_err", 64'(timeout_err), 64'd0);
        spart_req = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
